// File: rtl/wb_uart_rx.sv
// wb_uart_rx: 8N1 UART receiver with a one-byte holding buffer, read out
// over a pipelined Wishbone B4 slave (read-only, single data port).
//
// Parameters
//   TICKS_PER_BAUD : i_wb_clk cycles per UART bit (even, >= 4)
// Ports
//   i_wb_clk     : sole clock
//   i_wb_rst_n   : asynchronous active-low reset
//   i_wb_stb     : read request for the buffered byte
//   o_wb_stall   : high while no byte is buffered
//   o_wb_ack     : one-cycle acknowledge of an accepted request
//   o_wb_data    : received byte, valid while o_wb_ack is high
//   o_overrun    : sticky, a received byte was dropped (buffer full)
//   o_frame_err  : sticky, a stop bit was sampled low
//   i_uart_rx    : asynchronous serial line, idle high, LSB first
module wb_uart_rx #(
  parameter int unsigned TICKS_PER_BAUD = 8
) (
  input  logic       i_wb_clk,
  input  logic       i_wb_rst_n,
  input  logic       i_wb_stb,
  output logic       o_wb_stall,
  output logic       o_wb_ack,
  output logic [7:0] o_wb_data,
  output logic       o_overrun,
  output logic       o_frame_err,
  input  logic       i_uart_rx
);

  localparam int unsigned CNT_W = (TICKS_PER_BAUD > 2) ? $clog2(TICKS_PER_BAUD) : 1;
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(TICKS_PER_BAUD / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TICKS_PER_BAUD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_sync1;
  logic             r_sync2;
  logic [7:0]       r_buf;
  logic             r_valid;
  logic             r_ack;
  logic [7:0]       r_data;
  logic             r_overrun;
  logic             r_frame_err;

  logic w_rx;
  logic w_stop_tick;
  logic w_deliver;
  logic w_frame_bad;
  logic w_accept;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_uart_rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx        = r_sync2;
  assign w_stop_tick = (r_state == S_STOP) && (r_cnt == LAST_CNT);
  assign w_deliver   = w_stop_tick && w_rx;
  assign w_frame_bad = w_stop_tick && !w_rx;
  assign w_accept    = i_wb_stb && r_valid;

  // Receive FSM: start-bit qualification at half a bit, then one sample per
  // bit period so every sample lands at the bit centre.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_rx) begin
            r_state <= S_START;
          end
        end

        S_START: begin
          if (r_cnt == HALF_CNT) begin
            r_cnt <= '0;
            if (w_rx) begin
              // Line went back high before mid-bit: glitch, not a start bit.
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DATA;
              r_bit   <= '0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (r_cnt == LAST_CNT) begin
            r_cnt   <= '0;
            r_shift <= {w_rx, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_STOP: begin
          if (r_cnt == LAST_CNT) begin
            r_cnt   <= '0;
            r_state <= w_rx ? S_IDLE : S_WAIT_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_WAIT_IDLE: begin
          // A break holds the line low; wait it out without producing bytes.
          r_cnt <= '0;
          if (w_rx) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Holding buffer and Wishbone read port. A delivery coinciding with an
  // acceptance refills the buffer, so it is not an overrun.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      r_buf       <= '0;
      r_valid     <= 1'b0;
      r_ack       <= 1'b0;
      r_data      <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_ack <= w_accept;
      if (w_accept) begin
        r_data <= r_buf;
      end

      if (w_deliver && (w_accept || !r_valid)) begin
        r_buf   <= r_shift;
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end

      if (w_deliver && r_valid && !w_accept) begin
        r_overrun <= 1'b1;
      end else if (w_accept) begin
        r_overrun <= 1'b0;
      end

      // A new framing error wins over a clear in the same cycle so it is not lost.
      if (w_frame_bad) begin
        r_frame_err <= 1'b1;
      end else if (w_accept) begin
        r_frame_err <= 1'b0;
      end
    end
  end

  assign o_wb_stall  = ~r_valid;
  assign o_wb_ack    = r_ack;
  assign o_wb_data   = r_data;
  assign o_overrun   = r_overrun;
  assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_wb_uart_rx.sv
// Directed bench for wb_uart_rx at TICKS_PER_BAUD = 8.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_wb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stb;
  logic       stall;
  logic       ack;
  logic [7:0] data;
  logic       ovr;
  logic       ferr;
  logic       rx;

  int n_checks = 0;
  int n_err    = 0;

  // Values captured inside a frame at fixed tick offsets.
  logic       cap_stall78;
  logic       cap_stall79;
  logic       cap_ack;
  logic [7:0] cap_data;
  logic       cap_ovr;

  wb_uart_rx #(.TICKS_PER_BAUD(8)) dut (
    .i_wb_clk   (clk),
    .i_wb_rst_n (rst_n),
    .i_wb_stb   (stb),
    .o_wb_stall (stall),
    .o_wb_ack   (ack),
    .o_wb_data  (data),
    .o_overrun  (ovr),
    .o_frame_err(ferr),
    .i_uart_rx  (rx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one 8N1 frame (80 ticks) starting at the current falling edge.
  // Delivery lands on the rising edge between ticks 78 and 79.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int stb_at);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int n = 0; n < 80; n++) begin
      if (n == 78) cap_stall78 = stall;
      if (n == 79) begin
        cap_stall79 = stall;
        cap_ack     = ack;
        cap_data    = data;
        cap_ovr     = ovr;
      end
      rx  = bits[n/8];
      stb = (n == stb_at);
      @(negedge clk);
    end
    rx  = 1'b1;
    stb = 1'b0;
  endtask

  // Single read of a buffered byte, checking the ack cycle and the one after.
  task automatic read_byte(input logic [7:0] exp, input string tag);
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    check({tag, "_ack"},   32'(ack),   32'd1);
    check({tag, "_data"},  32'(data),  32'(exp));
    check({tag, "_stall"}, 32'(stall), 32'd1);
    check({tag, "_ovr"},   32'(ovr),   32'd0);
    check({tag, "_ferr"},  32'(ferr),  32'd0);
    @(negedge clk);
    check({tag, "_ack_off"},   32'(ack),  32'd0);
    check({tag, "_data_hold"}, 32'(data), 32'(exp));
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    stb   = 1'b0;
    idle(3);

    // Reset state
    check("rst_stall", 32'(stall), 32'd1);
    check("rst_ack",   32'(ack),   32'd0);
    check("rst_data",  32'(data),  32'd0);
    check("rst_ovr",   32'(ovr),   32'd0);
    check("rst_ferr",  32'(ferr),  32'd0);
    rst_n = 1'b1;
    idle(4);
    check("rel_ack",   32'(ack),   32'd0);
    check("rel_stall", 32'(stall), 32'd1);

    // Plain byte 0x55, delivery timing at the stop-bit centre
    send_frame(8'h55, 1'b1, -1);
    check("b55_stall_pre",  32'(cap_stall78), 32'd1);
    check("b55_stall_post", 32'(cap_stall79), 32'd0);
    idle(4);
    check("b55_stall", 32'(stall), 32'd0);
    check("b55_ovr",   32'(ovr),   32'd0);
    check("b55_ferr",  32'(ferr),  32'd0);
    read_byte(8'h55, "r55");

    // Three-cycle glitch on an idle line
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(20);
    check("glitch_stall", 32'(stall), 32'd1);
    check("glitch_ferr",  32'(ferr),  32'd0);
    check("glitch_ovr",   32'(ovr),   32'd0);

    // Framing error, then a clean byte
    send_frame(8'hA3, 1'b0, -1);
    idle(6);
    check("fe_ferr",  32'(ferr),  32'd1);
    check("fe_stall", 32'(stall), 32'd1);
    check("fe_ovr",   32'(ovr),   32'd0);
    send_frame(8'h0F, 1'b1, -1);
    idle(4);
    check("b0f_stall",     32'(stall), 32'd0);
    check("b0f_ferr_held", 32'(ferr),  32'd1);
    read_byte(8'h0F, "r0f");

    // Overrun: second byte dropped, first kept
    send_frame(8'h11, 1'b1, -1);
    idle(2);
    send_frame(8'h22, 1'b1, -1);
    idle(4);
    check("ovr_set",   32'(ovr),   32'd1);
    check("ovr_stall", 32'(stall), 32'd0);
    read_byte(8'h11, "r11");

    // Acceptance on the exact delivery edge of the second byte
    send_frame(8'h11, 1'b1, -1);
    idle(2);
    send_frame(8'h22, 1'b1, 78);
    check("same_ack",   32'(cap_ack),     32'd1);
    check("same_data",  32'(cap_data),   32'h11);
    check("same_ovr",   32'(cap_ovr),     32'd0);
    check("same_stall", 32'(cap_stall79), 32'd0);
    idle(2);
    check("same_ovr_after",   32'(ovr),   32'd0);
    check("same_stall_after", 32'(stall), 32'd0);
    check("same_ack_after",   32'(ack),   32'd0);
    read_byte(8'h22, "r22");

    // Reset during data bit 4 of 0xFF; release with the line low
    rx = 1'b0;
    idle(8);
    rx = 1'b1;
    idle(36);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack",   32'(ack),   32'd0);
    check("mid_rst_data",  32'(data),  32'd0);
    check("mid_rst_ovr",   32'(ovr),   32'd0);
    check("mid_rst_ferr",  32'(ferr),  32'd0);
    check("mid_rst_stall", 32'(stall), 32'd1);
    @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'h3C, 1'b1, -1);
    idle(4);
    check("b3c_stall", 32'(stall), 32'd0);
    check("b3c_ack",   32'(ack),   32'd0);
    check("b3c_ferr",  32'(ferr),  32'd0);
    read_byte(8'h3C, "r3c");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
